seg_scan_ctrl: RTL and testbench

Multiplexed seven-segment scan controller. It sits directly upstream of the 3-to-8 line decoder and the BCD-to-seven-segment decoder. It holds a double-buffered multi-digit BCD value and time-multiplexes it one digit at a time:
- sel drives the 3-to-8 decoder select input (digit strobe).
- bcd drives the BCD-to-seven-segment decoder input (segment pattern).
- dig_en drives the 3-to-8 decoder S1 enable.

---
 rtl/seg_scan_ctrl_if.sv | 24 ++
 rtl/seg_scan_ctrl.sv | 94 +++++++++
 tb/tb_seg_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between the scan controller and its host/display side.
// master: host that drives en/load/digits_in; slave: the scan controller itself.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic                en;
  logic                load;
  logic [4*DIGITS-1:0] digits_in;
  logic [2:0]          sel;
  logic [3:0]          bcd;
  logic                dig_en;
  logic                frame_done;
  logic                upd_pending;

  modport master (
    output en, load, digits_in,
    input  sel, bcd, dig_en, frame_done, upd_pending
  );

  modport slave (
    input  en, load, digits_in,
    output sel, bcd, dig_en, frame_done, upd_pending
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered BCD value.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int              CNT_W    = $clog2(CLK_DIV);
  localparam int              DW       = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       SEL_LAST = 3'(DIGITS - 1);

  logic [CNT_W-1:0] count;
  logic [2:0]       sel;
  logic [3:0]       bcd;
  logic             digEn;
  logic             frameDone;
  logic             updPending;
  logic [DW-1:0]    active;
  logic [DW-1:0]    pending;

  logic             tick;
  logic             wrap;
  logic [2:0]       selNext;
  logic [DW-1:0]    activeNext;
  logic [3:0]       bcdNext;
  logic             digEnNext;

  // bcd is derived from the post-edge sel/active so both registers always agree.
  always_comb begin
    tick    = bus.en && (count == CNT_LAST);
    wrap    = tick && (sel == SEL_LAST);
    selNext = sel;
    if (tick) selNext = wrap ? '0 : sel + 3'd1;
    activeNext = active;
    if (wrap && bus.load)       activeNext = bus.digits_in;
    else if (wrap && updPending) activeNext = pending;
    bcdNext = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (selNext == 3'(i)) bcdNext = activeNext[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic allZero;
  logic blankNext;

  // Walk down from the top digit; digit 0 is never blanked.
  always_comb begin
    allZero   = 1'b1;
    blankNext = 1'b0;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      allZero = allZero && (activeNext[4*i +: 4] == 4'h0);
      if (selNext == 3'(i) && allZero) blankNext = 1'b1;
    end
  end

  assign digEnNext = bus.en && !blankNext;
`else
  assign digEnNext = bus.en;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      sel        <= '0;
      bcd        <= '0;
      digEn      <= 1'b0;
      frameDone  <= 1'b0;
      updPending <= 1'b0;
      active     <= '0;
      pending    <= '0;
    end else begin
      if (bus.en) count <= tick ? '0 : count + CNT_W'(1);
      sel       <= selNext;
      bcd       <= bcdNext;
      active    <= activeNext;
      digEn     <= digEnNext;
      frameDone <= wrap;
      if (bus.load) pending <= bus.digits_in;
      if (wrap)          updPending <= 1'b0;
      else if (bus.load) updPending <= 1'b1;
    end
  end

  assign bus.sel         = sel;
  assign bus.bcd         = bcd;
  assign bus.dig_en      = digEn;
  assign bus.frame_done  = frameDone;
  assign bus.upd_pending = updPending;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed table, hand sequences, random vs. frame-level model.
module tb_seg_scan_ctrl;
  localparam int D = 4;
  localparam int C = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst1_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.DIGITS(D)) sb ();
  seg_scan_ctrl_if #(.DIGITS(1)) sb1 ();

  seg_scan_ctrl #(.DIGITS(D), .CLK_DIV(C)) dut  (.clk(clk), .rst_n(rst_n),  .bus(sb));
  seg_scan_ctrl #(.DIGITS(1), .CLK_DIV(2)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(sb1));

  int passCnt = 0;
  int total   = 0;

  // Model: a load takes effect at the start of a frame number; sel is a pure
  // function of the number of enabled clock edges since reset.
  typedef struct {
    logic [15:0] val;
    int          eff;
  } load_t;

  load_t       q[$];
  int          eCnt;
  logic [15:0] activeM;
  int          expSel;
  logic [3:0]  expBcd;
  logic        expFd;
  logic        expUpd;
  logic        expDig;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passCnt++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic modelReset();
    eCnt = 0;
    q.delete();
    activeM = '0;
    expSel = 0; expBcd = '0; expFd = 1'b0; expUpd = 1'b0; expDig = 1'b0;
  endtask

  task automatic modelEdge();
    int    f;
    logic  wrapEdge;
    load_t r;
    if (!rst_n) begin
      modelReset();
      return;
    end
    wrapEdge = 1'b0;
    if (sb.en) begin
      eCnt++;
      wrapEdge = (eCnt % (C * D)) == 0;
    end
    f = eCnt / (C * D);
    if (sb.load) begin
      r.val = sb.digits_in;
      r.eff = wrapEdge ? f : f + 1;
      q.push_back(r);
    end
    while (q.size() > 0 && q[0].eff <= f) begin
      r = q.pop_front();
      activeM = r.val;
    end
    expSel = (eCnt / C) % D;
    expBcd = 4'((activeM >> (4 * expSel)) & 16'hF);
    expFd  = wrapEdge;
    expUpd = q.size() > 0;
    expDig = sb.en;
`ifdef LEADING_ZERO_BLANK_EN
    if (expSel != 0 && (activeM >> (4 * expSel)) == 16'h0) expDig = 1'b0;
`endif
  endtask

  task automatic checkAll();
    chk("sel", sb.sel, expSel);
    chk("bcd", sb.bcd, expBcd);
    chk("frame_done", sb.frame_done, expFd);
    chk("upd_pending", sb.upd_pending, expUpd);
    chk("dig_en", sb.dig_en, expDig);
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  // Called just after a negedge: pulse reset low between clock edges.
  task automatic asyncReset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel", sb.sel, 0);
    chk("rst_bcd", sb.bcd, 0);
    chk("rst_dig_en", sb.dig_en, 0);
    chk("rst_frame_done", sb.frame_done, 0);
    chk("rst_upd_pending", sb.upd_pending, 0);
    modelReset();
    step();
    #2 rst_n = 1'b1;
  endtask

  task automatic runToWrap(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      step();
      sb.load = 1'b0;
      seen = expFd;
    end
    chk(name, seen, 1);
  endtask

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] din;
    int          n;
    int          sel;
    int          bcd;
    logic        fd;
    logic        upd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 16'h0000,  3, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000,  1, 1, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 11, 3, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000,  1, 0, 0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000,  1, 0, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000,  5, 1, 0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'h4321,  1, 1, 0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000,  8, 3, 0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000,  1, 0, 1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000,  4, 1, 2, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h0000,  4, 2, 3, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'h0000,  4, 3, 4, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'h0000,  3, 3, 4, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 16'h9876,  1, 0, 6, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 16'h0000,  4, 1, 7, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 16'h0000,  8, 3, 9, 1'b0, 1'b0};

    sb.en = 1'b0; sb.load = 1'b0; sb.digits_in = '0;
    sb1.en = 1'b0; sb1.load = 1'b0; sb1.digits_in = '0;
    modelReset();
    step();
    step();
    #2 rst_n = 1'b1;

    // Free-running scan, mid-frame load, load on the wrap edge.
    for (int r = 0; r < 16; r++) begin
      sb.en = tbl[r].en; sb.load = tbl[r].load; sb.digits_in = tbl[r].din;
      for (int k = 0; k < tbl[r].n; k++) begin
        step();
        sb.load = 1'b0;
      end
      chk($sformatf("tbl%0d_sel", r), sb.sel, tbl[r].sel);
      chk($sformatf("tbl%0d_bcd", r), sb.bcd, tbl[r].bcd);
      chk($sformatf("tbl%0d_fd", r), sb.frame_done, tbl[r].fd);
      chk($sformatf("tbl%0d_upd", r), sb.upd_pending, tbl[r].upd);
    end

    // Pause during digit 2, then resume.
    for (int k = 0; k < 13; k++) step();
    chk("pause_pre_sel", sb.sel, 2);
    chk("pause_pre_bcd", sb.bcd, 8);
    sb.en = 1'b0;
    step();
    chk("pause_dig_en", sb.dig_en, 0);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("pause_hold_sel", sb.sel, 2);
      chk("pause_hold_bcd", sb.bcd, 8);
    end
    sb.en = 1'b1;
    step();
    step();
    chk("resume_sel_hold", sb.sel, 2);
    step();
    chk("resume_sel", sb.sel, 3);
    chk("resume_bcd", sb.bcd, 9);

    // Async reset mid-frame with 4321 displayed.
    sb.load = 1'b1; sb.digits_in = 16'h4321;
    step();
    sb.load = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("prereset_sel", sb.sel, 1);
    chk("prereset_bcd", sb.bcd, 2);
    asyncReset();
    step();
    chk("postreset_sel", sb.sel, 0);
    chk("postreset_bcd", sb.bcd, 0);
    for (int k = 0; k < 16; k++) step();

`ifdef LEADING_ZERO_BLANK_EN
    sb.load = 1'b1; sb.digits_in = 16'h0050;
    runToWrap("lz50_wrap");
    chk("lz50_d0", sb.dig_en, 1);
    for (int k = 0; k < 4; k++) step();
    chk("lz50_d1", sb.dig_en, 1);
    for (int k = 0; k < 4; k++) step();
    chk("lz50_d2", sb.dig_en, 0);
    for (int k = 0; k < 4; k++) step();
    chk("lz50_d3", sb.dig_en, 0);
    sb.load = 1'b1; sb.digits_in = 16'h0000;
    runToWrap("lz00_wrap");
    chk("lz00_d0", sb.dig_en, 1);
    for (int k = 0; k < 4; k++) step();
    chk("lz00_d1", sb.dig_en, 0);
    for (int k = 0; k < 8; k++) step();
    chk("lz00_d3", sb.dig_en, 0);
`endif

    // Random traffic against the frame-level model.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      for (int j = 0; j < 4; j++) v[4*j +: 4] = ($urandom % 2) ? 4'($urandom % 16) : 4'h0;
      sb.en = ($urandom % 8) != 0;
      sb.load = ($urandom % 10) == 0;
      sb.digits_in = v;
      if (i == 1500) asyncReset();
      else step();
    end
    sb.load = 1'b0;
    sb.en = 1'b0;

    // Single-digit build: frame_done on every tick, sel pinned at 0.
    begin
      int fdE[6]  = '{0, 1, 0, 1, 0, 1};
      int updE[6] = '{0, 0, 1, 0, 0, 0};
      int bcdE[6] = '{0, 0, 0, 7, 7, 7};
      sb1.en = 1'b1; sb1.digits_in = 4'h7;
      #2 rst1_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
        sb1.load = (k == 2);
        step();
        chk("d1_sel", sb1.sel, 0);
        chk("d1_fd", sb1.frame_done, fdE[k]);
        chk("d1_upd", sb1.upd_pending, updE[k]);
        chk("d1_bcd", sb1.bcd, bcdE[k]);
      end
    end

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end
endmodule
